// File: rtl/hex_scan_ctrl_if.sv
// Display bus between game logic / board pins and the digit scan controller.
// The shared hex decoder sits outside the controller: dec_nib out, seg_in back.
interface hex_scan_ctrl_if #(
    parameter int unsigned NUM_DIGITS = 4
);
    logic                      load;
    logic [4*NUM_DIGITS-1:0]   value;
    logic [NUM_DIGITS-1:0]     blank_mask;
    logic [3:0]                dec_nib;
    logic [6:0]                seg_in;
    logic [6:0]                seg;
    logic [NUM_DIGITS-1:0]     an;
    logic                      frame_done;

    modport master (
        output load, value, blank_mask, seg_in,
        input  dec_nib, seg, an, frame_done
    );

    modport slave (
        input  load, value, blank_mask, seg_in,
        output dec_nib, seg, an, frame_done
    );
endinterface

// File: rtl/hex_scan_ctrl.sv
// Multiplexed common-anode 7-segment scanner: one shared decoder, a blanking gap
// before every digit, and display updates committed only at frame boundaries.
module hex_scan_ctrl #(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned DIV        = 50000,
    parameter int unsigned BLANK_CYC  = 16
) (
    input  logic          clk,
    input  logic          resetn,
    hex_scan_ctrl_if.slave bus
);

    localparam int unsigned VAL_W   = 4 * NUM_DIGITS;
    localparam int unsigned CNT_MAX = (DIV > BLANK_CYC) ? DIV : BLANK_CYC;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int unsigned IDX_W   = $clog2(NUM_DIGITS);

    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
    localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(DIV - 1);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [6:0]       SEG_OFF    = 7'h7F;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } state_t;

    state_t                  state_q,     state_d;
    logic [CNT_W-1:0]        cnt_q,       cnt_d;
    logic [IDX_W-1:0]        idx_q,       idx_d;
    logic [VAL_W-1:0]        pend_val_q,  pend_val_d;
    logic [NUM_DIGITS-1:0]   pend_mask_q, pend_mask_d;
    logic                    pend_flag_q, pend_flag_d;
    logic [VAL_W-1:0]        act_val_q,   act_val_d;
    logic [NUM_DIGITS-1:0]   act_mask_q,  act_mask_d;
    logic [6:0]              seg_q,       seg_d;
    logic [NUM_DIGITS-1:0]   an_q,        an_d;
    logic [3:0]              nib_q,       nib_d;
    logic                    fd_q,        fd_d;

    logic blank_end_c;
    logic drive_end_c;
    logic boundary_c;

    assign blank_end_c = (state_q == ST_BLANK) && (cnt_q == BLANK_LAST);
    assign drive_end_c = (state_q == ST_DRIVE) && (cnt_q == DRIVE_LAST);
    assign boundary_c  = drive_end_c && (idx_q == LAST_IDX);

    // Next-state: value staging, scan sequencing and registered pin values
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        pend_val_d  = pend_val_q;
        pend_mask_d = pend_mask_q;
        pend_flag_d = pend_flag_q;
        act_val_d   = act_val_q;
        act_mask_d  = act_mask_q;
        seg_d       = seg_q;
        an_d        = an_q;
        fd_d        = 1'b0;

        // A load on the boundary cycle bypasses the pending stage entirely
        if (boundary_c) begin
            pend_flag_d = 1'b0;
            fd_d        = 1'b1;
            if (bus.load) begin
                act_val_d  = bus.value;
                act_mask_d = bus.blank_mask;
            end else if (pend_flag_q) begin
                act_val_d  = pend_val_q;
                act_mask_d = pend_mask_q;
            end
        end else if (bus.load) begin
            pend_val_d  = bus.value;
            pend_mask_d = bus.blank_mask;
            pend_flag_d = 1'b1;
        end

        case (state_q)
            ST_BLANK: begin
                if (blank_end_c) begin
                    state_d = ST_DRIVE;
                    cnt_d   = '0;
                    if (!act_mask_q[idx_q]) begin
                        seg_d = bus.seg_in;
                        an_d  = ~(NUM_DIGITS'(1) << idx_q);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DRIVE: begin
                if (drive_end_c) begin
                    state_d = ST_BLANK;
                    cnt_d   = '0;
                    an_d    = '1;
                    seg_d   = SEG_OFF;
                    idx_d   = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_BLANK;
                cnt_d   = '0;
                an_d    = '1;
                seg_d   = SEG_OFF;
            end
        endcase

        // Decoder input tracks the upcoming digit, so it is settled for all of BLANK
        nib_d = act_val_d[{idx_d, 2'b00} +: 4];
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_BLANK;
            cnt_q       <= '0;
            idx_q       <= '0;
            pend_val_q  <= '0;
            pend_mask_q <= '0;
            pend_flag_q <= 1'b0;
            act_val_q   <= '0;
            act_mask_q  <= '0;
            seg_q       <= SEG_OFF;
            an_q        <= '1;
            nib_q       <= 4'h0;
            fd_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            pend_val_q  <= pend_val_d;
            pend_mask_q <= pend_mask_d;
            pend_flag_q <= pend_flag_d;
            act_val_q   <= act_val_d;
            act_mask_q  <= act_mask_d;
            seg_q       <= seg_d;
            an_q        <= an_d;
            nib_q       <= nib_d;
            fd_q        <= fd_d;
        end
    end

    assign bus.seg        = seg_q;
    assign bus.an         = an_q;
    assign bus.dec_nib    = nib_q;
    assign bus.frame_done = fd_q;

endmodule

// File: tb/tb_hex_scan_ctrl.sv
// Scoreboard bench for hex_scan_ctrl: a frame-level display model queues the
// expected pins for every cycle; a negedge monitor pops and compares.
module tb_hex_scan_ctrl;

    localparam int unsigned ND    = 4;
    localparam int unsigned DIVP  = 4;
    localparam int unsigned BC    = 2;
    localparam int unsigned SLOT  = BC + DIVP;
    localparam int unsigned FRAME = ND * SLOT;

    logic clk    = 1'b0;
    logic resetn = 1'b0;

    always #5 clk = ~clk;

    hex_scan_ctrl_if #(.NUM_DIGITS(ND)) bus ();

    hex_scan_ctrl #(
        .NUM_DIGITS(ND),
        .DIV       (DIVP),
        .BLANK_CYC (BC)
    ) dut (
        .clk   (clk),
        .resetn(resetn),
        .bus   (bus)
    );

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'h40;  4'h1: hex7 = 7'h79;  4'h2: hex7 = 7'h24;  4'h3: hex7 = 7'h30;
            4'h4: hex7 = 7'h19;  4'h5: hex7 = 7'h12;  4'h6: hex7 = 7'h02;  4'h7: hex7 = 7'h78;
            4'h8: hex7 = 7'h00;  4'h9: hex7 = 7'h10;  4'hA: hex7 = 7'h08;  4'hB: hex7 = 7'h03;
            4'hC: hex7 = 7'h46;  4'hD: hex7 = 7'h21;  4'hE: hex7 = 7'h06;  default: hex7 = 7'h0E;
        endcase
    endfunction

    assign bus.seg_in = hex7(bus.dec_nib);

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic [3:0] nib;
        logic       fd;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   mon_en   = 1'b0;

    // Display model state: cycle count since reset release and frame-level registers
    int          t = 0;
    logic [15:0] act_v  = '0, pend_v = '0;
    logic [3:0]  act_m  = '0, pend_m = '0;
    bit          pend_f = 1'b0;

    function automatic exp_t predict(input int tt, input logic [15:0] v, input logic [3:0] m);
        exp_t e;
        int pos;
        int d;
        pos   = tt % SLOT;
        d     = (tt / SLOT) % ND;
        e.nib = 4'(v >> (4 * d));
        e.fd  = (tt > 0) && (tt % FRAME == 0);
        if (pos < BC || m[d]) begin
            e.an  = 4'hF;
            e.seg = 7'h7F;
        end else begin
            e.an  = ~(4'(1) << d);
            e.seg = hex7(e.nib);
        end
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s t=%0d: got %h expected %h", name, t, act, req);
        end
    endtask

    // One cycle of stimulus: queue expectation, drive inputs, advance the model
    task automatic step(input bit ld, input logic [15:0] v, input logic [3:0] m);
        exp_q.push_back(predict(t, act_v, act_m));
        bus.load       = ld;
        bus.value      = v;
        bus.blank_mask = m;
        if (t % FRAME == FRAME - 1) begin
            if (ld) begin
                act_v = v;
                act_m = m;
            end else if (pend_f) begin
                act_v = pend_v;
                act_m = pend_m;
            end
            pend_f = 1'b0;
        end else if (ld) begin
            pend_v = v;
            pend_m = m;
            pend_f = 1'b1;
        end
        @(posedge clk);
        #1;
        t++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 16'($urandom), 4'($urandom));
    endtask

    task automatic idle_to(input int pos);
        while (t % FRAME != pos) step(1'b0, 16'($urandom), 4'($urandom));
    endtask

    task automatic do_reset();
        resetn   = 1'b0;
        bus.load = 1'b0;
        mon_en   = 1'b0;
        #1;
        check("async_an_dark", 32'(bus.an), 32'(4'hF));
        check("async_seg_dark", 32'(bus.seg), 32'(7'h7F));
        exp_q.delete();
        @(posedge clk);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        t      = 0;
        act_v  = '0;
        act_m  = '0;
        pend_v = '0;
        pend_m = '0;
        pend_f = 1'b0;
        mon_en = 1'b1;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            check("an_at_most_one_low", 32'($countones(~bus.an) <= 1), 32'(1));
            if (exp_q.size() == 0) begin
                check("scoreboard_nonempty", 32'(0), 32'(1));
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("an", 32'(bus.an), 32'(e.an));
                check("seg", 32'(bus.seg), 32'(e.seg));
                check("dec_nib", 32'(bus.dec_nib), 32'(e.nib));
                check("frame_done", 32'(bus.frame_done), 32'(e.fd));
            end
        end
    end

    initial begin
        bus.load       = 1'b0;
        bus.value      = '0;
        bus.blank_mask = '0;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Power-up scan of zeros, then a mid-frame load that must wait for the boundary
        idle(10);
        step(1'b1, 16'hF008, 4'h0);
        idle_to(0);
        idle(FRAME * 2);

        // Two loads in one frame: last write wins
        idle_to(5);
        step(1'b1, 16'h1111, 4'h0);
        idle(5);
        step(1'b1, 16'h2222, 4'h0);
        idle_to(0);
        idle(FRAME);

        // Boundary-cycle load overrides a pending value and commits immediately
        idle_to(7);
        step(1'b1, 16'h7777, 4'h0);
        idle_to(FRAME - 1);
        step(1'b1, 16'h9ABC, 4'h0);
        idle(FRAME);
        idle_to(FRAME - 1);
        step(1'b1, 16'h5A3C, 4'h0);
        idle(FRAME);

        // Masked digits stay dark but keep their slot
        idle_to(3);
        step(1'b1, 16'h8421, 4'b0101);
        idle_to(0);
        idle(FRAME * 2);

        // Reset at cycle 13 with a load pending: pending value must be lost
        do_reset();
        idle(5);
        step(1'b1, 16'hBEEF, 4'h0);
        idle_to(13);
        do_reset();
        idle(FRAME + 6);

        // Randomized loads, masks and occasional mid-scan resets
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 199) == 0)
                do_reset();
            else
                step(($urandom_range(0, 9) == 0), 16'($urandom), 4'($urandom));
        end

        mon_en = 1'b0;
        check("scoreboard_drained", 32'(exp_q.size()), 32'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hex_scan_ctrl.md
Name: hex_scan_ctrl

Overview:
- Time-multiplexes one shared hex-to-7-segment decoder across NUM_DIGITS common-anode digits that share one segment bus.
- Steps through the digits in turn, with a blanking gap between digits to suppress ghosting.
- New display values are held until the end of a frame so a frame is never torn.
- Sits between game logic (score/timer values) and the board's segment and anode pins; the decoder itself stays an external combinational instance.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits (2..8).
- DIV, 50000, clock cycles each digit is driven (>=1).
- BLANK_CYC, 16, clock cycles with all anodes off before each digit (>=1).

Ports:
- clk  input  1  system clock.
- resetn  input  1  asynchronous active-low reset.
- load  input  1  one-cycle strobe; captures value and blank_mask.
- value  input  4*NUM_DIGITS  packed nibbles; digit i = value[4i+3:4i].
- blank_mask  input  NUM_DIGITS  1 = digit i stays dark.
- dec_nib  output  4  nibble sent to the shared decoder input.
- seg_in  input  7  decoder output, active-low, bit0 = segment a.
- seg  output  7  segment pins, active-low, registered.
- an  output  NUM_DIGITS  anode enables, active-low, registered; at most one bit low.
- frame_done  output  1  one-cycle pulse when the last digit's drive slot ends.

Behaviour:
- Reset (resetn low, asynchronous):
  - state = BLANK, digit index = 0, counter = 0.
  - an = all 1s, seg = 7'h7F, dec_nib = 0, frame_done = 0.
  - Active and pending value and mask registers = 0; pending flag = 0.
- Registers: pending_val/pending_mask, active_val/active_mask, pending flag.
- load: pending <= {value, blank_mask}, pending flag set. A later load before the frame boundary overwrites the earlier one (last write wins).
- Frame boundary (last cycle of DRIVE for digit NUM_DIGITS-1):
  - If load is high this cycle, value/blank_mask go directly to active.
  - Otherwise, if the pending flag is set, pending goes to active.
  - The pending flag clears in either case. frame_done pulses high on the following cycle.
- FSM, two states:
  - BLANK:
    - an = all 1s, seg = 7'h7F.
    - dec_nib = active nibble of the current digit index; it is stable for the whole of BLANK.
    - Counter runs 0..BLANK_CYC-1, then DRIVE is entered and the counter resets.
  - DRIVE:
    - On the entry cycle, seg <= seg_in and an[idx] <= 0, unless active_mask[idx] = 1, in which case an stays all 1s and seg = 7'h7F.
    - seg and an hold for DIV cycles.
    - After the last DRIVE cycle: an <= all 1s, seg <= 7'h7F, the digit index increments (wrapping from NUM_DIGITS-1 to 0), and the FSM returns to BLANK.
- Masked digits keep their full slot, so frame period is always NUM_DIGITS*(BLANK_CYC+DIV) cycles.
- Timing:
  - From reset release, digit 0 drives at cycle BLANK_CYC.
  - A value captured at a boundary first appears on digit 0 BLANK_CYC cycles after that boundary.
- The counter is sized ceil(log2(max(DIV, BLANK_CYC))) bits and wraps only by explicit compare, never by overflow.
- An active-value update never lands mid-frame; active_* changes only at the boundary.
- Reset mid-frame: all outputs are dark immediately; pending loads are discarded.

Test Plan:
Bench uses NUM_DIGITS=4, DIV=4, BLANK_CYC=2 (slot 6, frame 24) and the team decoder (0 -> 7'h40, 8 -> 7'h00, F -> 7'h0E).
- Reset release, no load:
  - an = 4'b1111 at cycles 0-1; an = 4'b1110 at cycles 2-5 with seg = 7'h40.
  - an = 4'b1101 at cycles 8-11.
  - frame_done high at cycle 24.
- load value = 16'hF008 mid-frame 0:
  - Digits still show 0 until the boundary.
  - Frame 1 shows 8, 0, 0, F in turn: seg = 7'h00, 7'h40, 7'h40, 7'h0E.
- Two loads in one frame (16'h1111, then 16'h2222):
  - Only 2222 is displayed next frame.
  - load coincident with the boundary cycle commits that same value.
- blank_mask = 4'b0101:
  - an never goes low for digits 0 and 2; seg = 7'h7F in their slots.
  - Frame period is still 24 cycles.
- Anode check: assert continuously that at most one an bit is 0, and that an = all 1s throughout every BLANK window.
- resetn pulsed low at cycle 13 with a load pending:
  - an/seg go dark asynchronously.
  - After release, the display shows 0s and the pending value is lost.
